// File: rtl/vmem_seq_pkg.sv
// Shared types and default geometry for the vector/scalar memory sequencer.
package vmem_seq_pkg;
  localparam int XLEN_DEF            = 32;
  localparam int VLEN_DEF            = 128;
  localparam int DATA_ADDR_WIDTH_DEF = 10;
  localparam int NLANES_DEF          = VLEN_DEF / XLEN_DEF;

  typedef enum logic [1:0] {IDLE, V_ISSUE, V_DRAIN, V_DONE} vseq_state_e;

  // Lane counter width; a single-lane build still needs one bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vmem_addr_gen.sv
// Strided word-address accumulator: load base, then add stride per step, wrapping.
module vmem_addr_gen #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  output logic [AW-1:0] addr
);
  logic [AW-1:0] stride_q;

  // Modular AW-bit add gives both wrap-around and negative strides for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (step) begin
      addr     <= addr + stride_q;
    end
  end
endmodule

// File: rtl/vmem_access_sequencer.sv
// Shares the single DMEM port between scalar single-beat and vector multi-beat accesses.
module vmem_access_sequencer
  import vmem_seq_pkg::*;
#(
  parameter int XLEN            = XLEN_DEF,
  parameter int VLEN            = VLEN_DEF,
  parameter int DATA_ADDR_WIDTH = DATA_ADDR_WIDTH_DEF,
  localparam int NLANES         = VLEN / XLEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_req,
  input  logic                       s_we,
  input  logic [DATA_ADDR_WIDTH-1:0] s_addr,
  input  logic [XLEN-1:0]            s_wdata,
  output logic                       s_gnt,
  output logic                       s_rvalid,
  output logic [XLEN-1:0]            s_rdata,
  input  logic                       v_req,
  input  logic                       v_we,
  input  logic [DATA_ADDR_WIDTH-1:0] v_base,
  input  logic [DATA_ADDR_WIDTH-1:0] v_stride,
  input  logic [NLANES-1:0]          v_mask,
  input  logic [VLEN-1:0]            v_wdata,
  output logic                       v_ack,
  output logic                       v_done,
  output logic [VLEN-1:0]            v_rdata,
  output logic                       busy,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]            mem_wdata,
  input  logic [XLEN-1:0]            mem_rdata
);
  localparam int LW = lane_w(NLANES);

  vseq_state_e                state_q, state_d;
  logic [LW-1:0]              lane_q;
  logic                       we_q;
  logic [NLANES-1:0]          mask_q;
  logic [VLEN-1:0]            wdata_q;
  logic                       fair_q;
  logic                       s_rvalid_q;
  logic                       cap_q, cap_en_q;
  logic [LW-1:0]              cap_lane_q;
  logic [VLEN-1:0]            v_rdata_q;
  logic [DATA_ADDR_WIDTH-1:0] lane_addr;
  logic                       last_lane;

  assign last_lane = (lane_q == LW'(NLANES - 1));

  vmem_addr_gen #(.AW(DATA_ADDR_WIDTH)) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (v_ack),
    .step   (state_q == V_ISSUE),
    .base   (v_base),
    .stride (v_stride),
    .addr   (lane_addr)
  );

  always_comb begin
    state_d   = state_q;
    s_gnt     = 1'b0;
    v_ack     = 1'b0;
    v_done    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        // Scalar wins ties unless the vector already lost one.
        s_gnt = s_req & ~(v_req & fair_q);
        v_ack = v_req & ~s_gnt;
        if (s_gnt) begin
          mem_en    = 1'b1;
          mem_we    = s_we;
          mem_addr  = s_addr;
          mem_wdata = s_wdata;
        end
        if (v_ack) state_d = V_ISSUE;
      end
      V_ISSUE: begin
        mem_en    = mask_q[lane_q];
        mem_we    = we_q;
        mem_addr  = lane_addr;
        mem_wdata = wdata_q[lane_q*XLEN +: XLEN];
        if (last_lane) state_d = we_q ? V_DONE : V_DRAIN;
      end
      V_DRAIN: state_d = V_DONE;
      V_DONE: begin
        v_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      we_q       <= 1'b0;
      mask_q     <= '0;
      wdata_q    <= '0;
      fair_q     <= 1'b0;
      s_rvalid_q <= 1'b0;
      cap_q      <= 1'b0;
      cap_en_q   <= 1'b0;
      cap_lane_q <= '0;
      v_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_rvalid_q <= s_gnt & ~s_we;
      if (v_ack)              fair_q <= 1'b0;
      else if (s_gnt & v_req) fair_q <= 1'b1;
      if (v_ack) begin
        we_q    <= v_we;
        mask_q  <= v_mask;
        wdata_q <= v_wdata;
        lane_q  <= '0;
      end else if (state_q == V_ISSUE) begin
        lane_q  <= lane_q + LW'(1);
      end
      // Load data returns one cycle after its lane issues; skipped lanes read as 0.
      cap_q      <= (state_q == V_ISSUE) & ~we_q;
      cap_en_q   <= mask_q[lane_q];
      cap_lane_q <= lane_q;
      if (cap_q) v_rdata_q[cap_lane_q*XLEN +: XLEN] <= cap_en_q ? mem_rdata : '0;
    end
  end

  assign s_rvalid = s_rvalid_q;
  assign s_rdata  = s_rvalid_q ? mem_rdata : '0;
  assign v_rdata  = v_rdata_q;
  assign busy     = (state_q != IDLE);
endmodule
